// File: rtl/tetris_pkg.sv
// Shared encodings for the move-command path: sel codes, button indices and repeat FSM states.
package tetris_pkg;

    localparam logic [1:0] SEL_ROT   = 2'b00;
    localparam logic [1:0] SEL_LEFT  = 2'b01;
    localparam logic [1:0] SEL_RIGHT = 2'b10;
    localparam logic [1:0] SEL_FALL  = 2'b11;

    localparam int unsigned BTN_ROT   = 0;
    localparam int unsigned BTN_LEFT  = 1;
    localparam int unsigned BTN_RIGHT = 2;
    localparam int unsigned BTN_DOWN  = 3;

    localparam logic [1:0] RPT_IDLE   = 2'b00;
    localparam logic [1:0] RPT_DELAY  = 2'b01;
    localparam logic [1:0] RPT_REPEAT = 2'b10;

    typedef struct packed {
        logic fall;
        logic rot;
        logic left;
        logic right;
    } pend_t;

    function automatic int unsigned umax(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // One spare bit so a counter holding the largest period value can never wrap.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return $clog2(max_val) + 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a stability counter; the level only moves
// after DEB_CYCLES consecutive samples disagree with it.
module btn_debounce #(
    parameter int unsigned DEB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic level_o
);

    localparam int unsigned   CW       = $clog2(DEB_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          meta_q;
    logic          sync_q;
    logic          level_q;
    logic          level_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (sync_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            level_d = sync_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            meta_q  <= btn_i;
            sync_q  <= meta_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/move_cmd_gen.sv
// Turns the raw board buttons and the gravity tick into single-cycle move
// commands on sel, qualified by sel_valid, for mem_addr_gen.
module move_cmd_gen
    import tetris_pkg::*;
#(
    parameter int unsigned DEB_CYCLES       = 1_000_000,
    parameter int unsigned REPEAT_DELAY     = 25_000_000,
    parameter int unsigned REPEAT_RATE      = 10_000_000,
    parameter int unsigned FALL_PERIOD      = 50_000_000,
    parameter int unsigned SOFT_FALL_PERIOD = 5_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_rot,
    input  logic       btn_down,
    input  logic       stop,
    input  logic       gameover,
    output logic [1:0] sel,
    output logic       sel_valid
);

    localparam int unsigned   RW         = cnt_width(umax(REPEAT_DELAY, REPEAT_RATE));
    localparam int unsigned   GW         = cnt_width(umax(FALL_PERIOD, SOFT_FALL_PERIOD));
    localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);
    localparam logic [GW-1:0] FALL_LAST  = GW'(FALL_PERIOD - 1);
    localparam logic [GW-1:0] SOFT_LAST  = GW'(SOFT_FALL_PERIOD - 1);

    logic [3:0] btn_raw;
    logic [3:0] btn_lvl;
    logic [2:0] lvl_prev_q;
    logic [2:0] btn_rise;
    logic [1:0] dir_lvl;
    logic [1:0] dir_rise;
    logic       both_held;

    // Index 0 = left, 1 = right.
    logic [1:0][1:0]    rpt_state_q;
    logic [1:0][1:0]    rpt_state_d;
    logic [1:0][RW-1:0] rpt_cnt_q;
    logic [1:0][RW-1:0] rpt_cnt_d;
    logic [1:0]         rpt_fire;

    logic [GW-1:0] grav_cnt_q;
    logic [GW-1:0] grav_cnt_d;
    logic [GW-1:0] period_last;
    logic          fall_wrap;

    pend_t      pend_q;
    pend_t      pend_d;
    pend_t      req;
    logic [1:0] sel_q;
    logic [1:0] sel_d;
    logic       sel_valid_q;
    logic       sel_valid_d;

    assign btn_raw = {btn_down, btn_right, btn_left, btn_rot};

    for (genvar g = 0; g < 4; g++) begin : g_deb
        btn_debounce #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_deb (
            .clk    (clk),
            .rst    (rst),
            .btn_i  (btn_raw[g]),
            .level_o(btn_lvl[g])
        );
    end

    assign btn_rise  = btn_lvl[2:0] & ~lvl_prev_q;
    assign dir_lvl   = btn_lvl[BTN_RIGHT:BTN_LEFT];
    assign dir_rise  = btn_rise[BTN_RIGHT:BTN_LEFT];
    assign both_held = &dir_lvl;

    // Auto-repeat for left/right; a release, a chord of both, or gameover
    // returns to IDLE, so a fresh press is needed to restart the sequence.
    always_comb begin
        rpt_state_d = rpt_state_q;
        rpt_cnt_d   = rpt_cnt_q;
        rpt_fire    = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            if (gameover || both_held || !dir_lvl[i]) begin
                rpt_state_d[i] = RPT_IDLE;
                rpt_cnt_d[i]   = '0;
            end else begin
                case (rpt_state_q[i])
                    RPT_IDLE: begin
                        if (dir_rise[i]) begin
                            rpt_state_d[i] = RPT_DELAY;
                            rpt_cnt_d[i]   = '0;
                        end
                    end
                    RPT_DELAY: begin
                        if (rpt_cnt_q[i] == DELAY_LAST) begin
                            rpt_state_d[i] = RPT_REPEAT;
                            rpt_cnt_d[i]   = '0;
                            rpt_fire[i]    = 1'b1;
                        end else begin
                            rpt_cnt_d[i] = rpt_cnt_q[i] + RW'(1);
                        end
                    end
                    RPT_REPEAT: begin
                        if (rpt_cnt_q[i] == RATE_LAST) begin
                            rpt_cnt_d[i] = '0;
                            rpt_fire[i]  = 1'b1;
                        end else begin
                            rpt_cnt_d[i] = rpt_cnt_q[i] + RW'(1);
                        end
                    end
                    default: begin
                        rpt_state_d[i] = RPT_IDLE;
                        rpt_cnt_d[i]   = '0;
                    end
                endcase
            end
        end
    end

    // >= rather than == so a switch to the shorter soft-drop period wraps at once.
    assign period_last = btn_lvl[BTN_DOWN] ? SOFT_LAST : FALL_LAST;

    always_comb begin
        grav_cnt_d = grav_cnt_q;
        fall_wrap  = 1'b0;
        if (stop) begin
            grav_cnt_d = '0;
        end else if (gameover) begin
            grav_cnt_d = grav_cnt_q;
        end else if (grav_cnt_q >= period_last) begin
            grav_cnt_d = '0;
            fall_wrap  = 1'b1;
        end else begin
            grav_cnt_d = grav_cnt_q + GW'(1);
        end
    end

    // New requests merge into the pending set before arbitration so a flag
    // raised this cycle can be granted this cycle.
    always_comb begin
        req = pend_q;
        if (btn_rise[BTN_ROT]) begin
            req.rot = 1'b1;
        end
        if (dir_rise[0] || rpt_fire[0]) begin
            req.left = 1'b1;
        end
        if (dir_rise[1] || rpt_fire[1]) begin
            req.right = 1'b1;
        end
        if (fall_wrap) begin
            req.fall = 1'b1;
        end
        if (stop) begin
            req.fall = 1'b0;
        end
        if (both_held) begin
            req.left  = 1'b0;
            req.right = 1'b0;
        end
        if (gameover) begin
            req = '0;
        end

        pend_d      = req;
        sel_d       = SEL_ROT;
        sel_valid_d = 1'b0;
        if (!sel_valid_q) begin
            if (req.fall) begin
                pend_d.fall = 1'b0;
                sel_d       = SEL_FALL;
                sel_valid_d = 1'b1;
            end else if (req.rot) begin
                pend_d.rot  = 1'b0;
                sel_d       = SEL_ROT;
                sel_valid_d = 1'b1;
            end else if (req.left) begin
                pend_d.left = 1'b0;
                sel_d       = SEL_LEFT;
                sel_valid_d = 1'b1;
            end else if (req.right) begin
                pend_d.right = 1'b0;
                sel_d        = SEL_RIGHT;
                sel_valid_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lvl_prev_q  <= '0;
            rpt_state_q <= {RPT_IDLE, RPT_IDLE};
            rpt_cnt_q   <= '0;
            grav_cnt_q  <= '0;
            pend_q      <= '0;
            sel_q       <= SEL_ROT;
            sel_valid_q <= 1'b0;
        end else begin
            lvl_prev_q  <= btn_lvl[2:0];
            rpt_state_q <= rpt_state_d;
            rpt_cnt_q   <= rpt_cnt_d;
            grav_cnt_q  <= grav_cnt_d;
            pend_q      <= pend_d;
            sel_q       <= sel_d;
            sel_valid_q <= sel_valid_d;
        end
    end

    assign sel       = sel_q;
    assign sel_valid = sel_valid_q;

endmodule

// File: tb/tb_move_cmd_gen.sv
// Scoreboard bench for move_cmd_gen: stimulus pushes hand-computed strobes
// (cycle, sel); a negedge monitor pops and compares every cycle.
module tb_move_cmd_gen;
    import tetris_pkg::*;

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic       btn_left  = 1'b0;
    logic       btn_right = 1'b0;
    logic       btn_rot   = 1'b0;
    logic       btn_down  = 1'b0;
    logic       stop      = 1'b1;
    logic       gameover  = 1'b0;
    logic [1:0] sel;
    logic       sel_valid;

    int cyc    = 0;
    int tests  = 0;
    int failed = 0;

    typedef struct {
        int         cyc;
        logic [1:0] sel;
    } exp_t;

    exp_t exp_q[$];
    logic prev_valid = 1'b0;

    move_cmd_gen #(
        .DEB_CYCLES      (4),
        .REPEAT_DELAY    (20),
        .REPEAT_RATE     (8),
        .FALL_PERIOD     (50),
        .SOFT_FALL_PERIOD(10)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_left (btn_left),
        .btn_right(btn_right),
        .btn_rot  (btn_rot),
        .btn_down (btn_down),
        .stop     (stop),
        .gameover (gameover),
        .sel      (sel),
        .sel_valid(sel_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Cycle n = the interval after the n-th rising edge; inputs change and
    // outputs are sampled on the falling edge inside that interval.
    task automatic at_cycle(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic expect_strobe(input int c, input logic [1:0] s);
        exp_t e;
        e.cyc = c;
        e.sel = s;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (cyc >= 1) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                tests++;
                failed++;
                $display("FAIL strobe_missing: no strobe at cycle %0d, required sel=%b", exp_q[0].cyc, exp_q[0].sel);
                void'(exp_q.pop_front());
            end
            if (sel_valid === 1'b1) begin
                tests++;
                if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                    if (sel !== exp_q[0].sel) begin
                        failed++;
                        $display("FAIL strobe_sel: cycle %0d got sel=%b, required %b", cyc, sel, exp_q[0].sel);
                    end
                    void'(exp_q.pop_front());
                end else begin
                    failed++;
                    $display("FAIL unexpected_strobe: cycle %0d got sel_valid=1 sel=%b, required sel_valid=0", cyc, sel);
                end
                tests++;
                if (prev_valid === 1'b1) begin
                    failed++;
                    $display("FAIL back_to_back: cycle %0d sel_valid=1 after a strobe, required 0", cyc);
                end
            end else begin
                tests++;
                if (sel_valid !== 1'b0 || sel !== SEL_ROT) begin
                    failed++;
                    $display("FAIL %s: cycle %0d got sel_valid=%b sel=%b, required 0 00",
                             (rst === 1'b1) ? "reset_state" : "idle_out", cyc, sel_valid, sel);
                end
            end
            prev_valid = sel_valid;
        end
    end

    initial begin
        int t;

        // 1: reset for 3 cycles, single rot press, no repeat for rotate.
        at_cycle(3);
        rst = 1'b0;
        t = 10;
        expect_strobe(t + 7, SEL_ROT);
        at_cycle(t);      btn_rot = 1'b1;
        at_cycle(t + 10); btn_rot = 1'b0;
        at_cycle(t + 60);

        // 2: left bounces with 2-cycle runs, then settles high.
        t = 70;
        expect_strobe(t + 19, SEL_LEFT);
        for (int k = 0; k < 12; k++) begin
            at_cycle(t + k);
            btn_left = ((k / 2) % 2 == 0);
        end
        at_cycle(t + 12); btn_left = 1'b1;
        at_cycle(t + 22); btn_left = 1'b0;
        at_cycle(t + 50);

        // 3: right held 60 cycles: press, first repeat after 20, then every 8.
        t = 130;
        expect_strobe(t + 7,  SEL_RIGHT);
        expect_strobe(t + 27, SEL_RIGHT);
        expect_strobe(t + 35, SEL_RIGHT);
        expect_strobe(t + 43, SEL_RIGHT);
        expect_strobe(t + 51, SEL_RIGHT);
        expect_strobe(t + 59, SEL_RIGHT);
        at_cycle(t);      btn_right = 1'b1;
        at_cycle(t + 60); btn_right = 1'b0;
        at_cycle(t + 90);

        // 4: gravity at 50, soft drop at 10 (count above new period wraps
        //    next cycle), then a stop pulse restarts the period.
        t = 230;
        expect_strobe(t + 50,  SEL_FALL);
        expect_strobe(t + 100, SEL_FALL);
        expect_strobe(t + 112, SEL_FALL);
        expect_strobe(t + 122, SEL_FALL);
        expect_strobe(t + 132, SEL_FALL);
        expect_strobe(t + 201, SEL_FALL);
        at_cycle(t);       stop = 1'b0;
        at_cycle(t + 105); btn_down = 1'b1;
        at_cycle(t + 134); btn_down = 1'b0;
        at_cycle(t + 150); stop = 1'b1;
        at_cycle(t + 151); stop = 1'b0;
        at_cycle(t + 205); stop = 1'b1;
        at_cycle(t + 215);

        // 5: rot and left requests land on the same cycle as a fall wrap.
        t = 460;
        expect_strobe(t + 50, SEL_FALL);
        expect_strobe(t + 52, SEL_ROT);
        expect_strobe(t + 54, SEL_LEFT);
        at_cycle(t);      stop = 1'b0;
        at_cycle(t + 43); btn_rot = 1'b1; btn_left = 1'b1;
        at_cycle(t + 53); btn_rot = 1'b0; btn_left = 1'b0;
        at_cycle(t + 60); stop = 1'b1;
        at_cycle(t + 80);

        // 6: gameover while right repeats and fall is pending behind it.
        t = 570;
        expect_strobe(t + 7,   SEL_RIGHT);
        expect_strobe(t + 27,  SEL_RIGHT);
        expect_strobe(t + 100, SEL_FALL);
        expect_strobe(t + 137, SEL_RIGHT);
        at_cycle(t - 22);  stop = 1'b0;
        at_cycle(t);       btn_right = 1'b1;
        at_cycle(t + 28);  gameover = 1'b1;
        at_cycle(t + 30);  btn_rot = 1'b1;
        at_cycle(t + 40);  btn_rot = 1'b0;
        at_cycle(t + 50);  gameover = 1'b0;
        at_cycle(t + 105); stop = 1'b1;
        at_cycle(t + 110); btn_right = 1'b0;
        at_cycle(t + 130); btn_right = 1'b1;
        at_cycle(t + 140); btn_right = 1'b0;
        at_cycle(t + 180);

        // 7: reset in the middle of a left debounce drops that press.
        t = 760;
        at_cycle(t);      btn_left = 1'b1;
        at_cycle(t + 3);  rst = 1'b1;
        at_cycle(t + 5);  rst = 1'b0; btn_left = 1'b0;
        at_cycle(t + 40);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
